note_recorder: RTL and testbench
================================

NOTE_RECORDER -- requirements
Module: note_recorder

Interface
REQ-001 Parameter DEPTH, default 32, event buffer depth in entries, power of two, 4..64.
REQ-002 Parameter DUR_W, default 8, duration field width in ticks.
REQ-003 Parameter TICK_DIV, default 10_000_000, clk cycles per duration tick (0.1 s at 100 MHz).
REQ-004 The block SHALL have one clock, clk, and an asynchronous, active-low reset named reset.
REQ-005 Port clk, input, 1 bit: system clock, all state updates on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port note_in, input, 4 bits: live note from keyboard controller; 0 = rest, 1..7 = do..si, 8..15 treated as rest.
REQ-008 Port write_on, input, 1 bit: level, recording requested.
REQ-009 Port play, input, 1 bit: single-cycle pulse, start playback.
REQ-010 Port stop, input, 1 bit: single-cycle pulse, abort playback.
REQ-011 Port note_out, output, 4 bits: note to buzzer.
REQ-012 Port recording, output, 1 bit: high in REC.
REQ-013 Port playing, output, 1 bit: high in PLAY.
REQ-014 Port count, output, 7 bits: number of stored events, 0..DEPTH.
REQ-015 Port full, output, 1 bit: count == DEPTH.
REQ-016 Port done, output, 1 bit: one-cycle pulse when playback completes normally.

Function
REQ-017 FSM states IDLE, REC, PLAY; all transitions registered, taking effect one cycle after the causing input.
REQ-018 IDLE->REC on a rising edge of write_on (registered previous value); entry clears count to 0, loads current note = note_in, duration = 0, tick prescaler = 0.
REQ-019 Tick prescaler counts 0..TICK_DIV-1 and restarts on every state entry and on every new event; a wrap increments duration.
REQ-020 In REC, when note_in differs from the current note, the block SHALL store {current note, duration} at index count and increment count, then start a new event with the new note at duration 0.
REQ-021 Events with duration 0 SHALL be discarded, not stored; count is unchanged.
REQ-022 When duration reaches 2^DUR_W-1, the event SHALL be stored and a new event with the same note started at duration 0.
REQ-023 When full is high, store requests SHALL be dropped; the FSM stays in REC until write_on falls.
REQ-024 REC->IDLE when write_on is low; the pending event is stored if duration > 0 and not full.
REQ-025 IDLE->PLAY on play when count > 0; play when count == 0 is ignored. The cycle after the play pulse, playing = 1 and note_out = note of entry 0.
REQ-026 In PLAY, each entry drives note_out for exactly duration × TICK_DIV cycles, then the next entry is loaded with no gap cycle.
REQ-027 After the last entry (index count-1) expires: done pulses for 1 cycle, note_out = 0 for that cycle, and the FSM enters IDLE.
REQ-028 In PLAY, stop or write_on high SHALL abort to IDLE with no done pulse; stop has priority. Recording requires a fresh write_on rising edge in IDLE.
REQ-029 play and stop in REC are ignored; stop in IDLE is ignored.
REQ-030 In IDLE and REC, note_out SHALL equal note_in (registered, 1-cycle latency), with 8..15 mapped to 0.
REQ-031 Buffer contents and count persist across IDLE and PLAY; only REC entry clears count.

Reset
REQ-032 reset low SHALL asynchronously force: state IDLE, note_out 0, recording 0, playing 0, count 0, full 0, done 0, prescaler 0, read pointer 0; buffer contents need not be cleared.
REQ-033 Reset mid-REC or mid-PLAY discards the session; after release count = 0.

Configuration
REQ-034 Macro NOTE_REC_LOOP_EN: when defined, PLAY SHALL restart from entry 0 after the last entry instead of finishing, done never pulses, and only stop, write_on or reset exits PLAY; when undefined, REQ-027 applies.

Verification (TICK_DIV=4, DUR_W=8, DEPTH=4)
REQ-035 Record: write_on=1; note_in 3 for 8 cycles, 5 for 12 cycles; write_on=0 -> count=2, entries {3,2},{5,3}.
REQ-036 Play after REQ-035: play pulse -> note_out 3 for 8 cycles, then 5 for 12 cycles, done pulse, note_out 0, playing 0.
REQ-037 Glitch: note_in 6 for 2 cycles between two 8-cycle runs of note 1 -> 6 not stored; count=2, entries {1,2},{1,2}.
REQ-038 Full: 6 distinct notes each 8 cycles -> count stops at 4, full=1, FSM stays in REC until write_on=0.
REQ-039 Abort: stop mid-entry 0 -> next cycle playing=0, note_out follows note_in, no done; play with count=0 -> no change.
REQ-040 Reset low mid-PLAY -> all outputs 0 immediately; loop build: after last entry note_out returns to entry 0 note.

Source files
------------

// File: rtl/note_recorder.sv
// note_recorder: records a live note stream as {note, duration} events into a
// small buffer and plays them back to a buzzer at the recorded tempo.
//
// Duration is measured in ticks of TICK_DIV clk cycles. An event is closed
// when the note changes, when its duration saturates, or when recording ends.
// An event is only stored if it lasted at least one tick.
//
// Build option: define NOTE_REC_LOOP_EN to make playback wrap from the last
// entry back to entry 0 indefinitely. In that build done never pulses, and
// PLAY is left only through stop, write_on or reset.
module note_recorder #(
  parameter int DEPTH    = 32,
  parameter int DUR_W    = 8,
  parameter int TICK_DIV = 10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] note_in,
  input  logic       write_on,
  input  logic       play,
  input  logic       stop,
  output logic [3:0] note_out,
  output logic       recording,
  output logic       playing,
  output logic [6:0] count,
  output logic       full,
  output logic       done
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] DUR_MAX    = '1;
  localparam logic [DUR_W-1:0] DUR_ONE    = DUR_W'(1);
  localparam logic [6:0]       COUNT_FULL = 7'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REC,
    PLAY
  } state_t;

  typedef struct packed {
    logic [3:0]       note;
    logic [DUR_W-1:0] dur;
  } entry_t;

  // Registered state and its next-state values
  state_t           state_q, state_d;
  logic             write_on_q;
  logic [3:0]       cur_note_q, cur_note_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [6:0]       count_q, count_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DUR_W-1:0] pdur_q, pdur_d;
  logic [3:0]       note_out_q, note_out_d;
  logic             done_q, done_d;

  // Event buffer and its write port
  entry_t           mem [DEPTH];
  logic             store_en;
  entry_t           store_data;

  // Helper terms shared by the next-state logic
  logic [3:0]       note_live;
  logic             tick;
  logic [DUR_W-1:0] dur_eff;
  logic             write_rise;
  logic             is_full;
  logic [AW-1:0]    nxt_ptr;
  entry_t           head_entry;
  entry_t           nxt_entry;
  logic             last_entry;

  // Notes 8..15 are treated as rests.
  assign note_live  = note_in[3] ? 4'd0 : note_in;
  assign tick       = (presc_q == PRESC_LAST);
  // Duration including the tick that completes on this very cycle, so an
  // event closed on a prescaler wrap is credited with that final tick.
  assign dur_eff    = dur_q + DUR_W'(tick);
  assign write_rise = write_on & ~write_on_q;
  assign is_full    = (count_q == COUNT_FULL);
  assign nxt_ptr    = rd_ptr_q + 1'b1;
  assign head_entry = mem[0];
  assign nxt_entry  = mem[nxt_ptr];
  assign last_entry = ((7'(rd_ptr_q) + 7'd1) == count_q);

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state, datapath and output decode
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path through
    // this block can leave one unassigned and infer a latch.
    state_d              = state_q;
    cur_note_d           = cur_note_q;
    dur_d                = dur_q;
    presc_d              = '0;
    count_d              = count_q;
    rd_ptr_d             = rd_ptr_q;
    pdur_d               = pdur_q;
    note_out_d           = note_live;
    done_d               = 1'b0;
    store_en             = 1'b0;
    store_data.note      = cur_note_q;
    store_data.dur       = dur_eff;

    case (state_q)
      IDLE: begin
        if (write_rise) begin
          state_d    = REC;
          cur_note_d = note_live;
          dur_d      = '0;
          count_d    = '0;
        end else if (play && (count_q != '0)) begin
          state_d    = PLAY;
          rd_ptr_d   = '0;
          note_out_d = head_entry.note;
          pdur_d     = head_entry.dur;
        end
      end

      REC: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        dur_d   = dur_eff;
        if (!write_on) begin
          // Flush the pending event on the way out.
          state_d  = IDLE;
          presc_d  = '0;
          store_en = (dur_eff != '0) && !is_full;
        end else if (note_live != cur_note_q) begin
          // Close the current event; a zero-length one is a glitch and dropped.
          store_en   = (dur_eff != '0) && !is_full;
          cur_note_d = note_live;
          dur_d      = '0;
          presc_d    = '0;
        end else if (dur_eff == DUR_MAX) begin
          // Saturated duration: split into a new event with the same note.
          store_en = !is_full;
          dur_d    = '0;
          presc_d  = '0;
        end
        if (store_en) count_d = count_q + 7'd1;
      end

      PLAY: begin
        note_out_d = note_out_q;
        presc_d    = tick ? '0 : presc_q + 1'b1;
        if (stop || write_on) begin
          state_d    = IDLE;
          presc_d    = '0;
          rd_ptr_d   = '0;
          note_out_d = note_live;
        end else if (tick) begin
          if (pdur_q != DUR_ONE) begin
            pdur_d = pdur_q - 1'b1;
          end else if (!last_entry) begin
            rd_ptr_d   = nxt_ptr;
            note_out_d = nxt_entry.note;
            pdur_d     = nxt_entry.dur;
          end else begin
`ifdef NOTE_REC_LOOP_EN
            rd_ptr_d   = '0;
            note_out_d = head_entry.note;
            pdur_d     = head_entry.dur;
`else
            state_d    = IDLE;
            rd_ptr_d   = '0;
            note_out_d = 4'd0;
            done_d     = 1'b1;
`endif
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_on_q <= 1'b0;
      cur_note_q <= '0;
      dur_q      <= '0;
      presc_q    <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      pdur_q     <= '0;
      note_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      write_on_q <= write_on;
      cur_note_q <= cur_note_d;
      dur_q      <= dur_d;
      presc_q    <= presc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      pdur_q     <= pdur_d;
      note_out_q <= note_out_d;
      done_q     <= done_d;
    end
  end

  // Event buffer write port
  // NOTE: the buffer is deliberately not reset; count gates every read, so
  // stale contents are never observed and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (store_en) mem[count_q[AW-1:0]] <= store_data;
  end

  assign note_out  = note_out_q;
  assign recording = (state_q == REC);
  assign playing   = (state_q == PLAY);
  assign count     = count_q;
  assign full      = is_full;
  assign done      = done_q;

endmodule

// File: tb/tb_note_recorder.sv
// Testbench for note_recorder (DEPTH=4, DUR_W=8, TICK_DIV=4).
// Recorded runs are turned into expected buffer entries; playback pushes the
// expected per-cycle {done, playing, note_out} onto a scoreboard that is
// popped and compared as the DUT produces each cycle.
module tb_note_recorder;

  localparam int DEPTH    = 4;
  localparam int DUR_W    = 8;
  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] note_in;
  logic       write_on;
  logic       play;
  logic       stop;
  logic [3:0] note_out;
  logic       recording;
  logic       playing;
  logic [6:0] count;
  logic       full;
  logic       done;

  typedef struct {
    logic [3:0] note;
    int         dur;
  } exp_entry_t;

  exp_entry_t exp_entries[$];
  logic [5:0] sb[$];
  logic [3:0] run_notes[$];
  int         run_lens[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  note_recorder #(
    .DEPTH   (DEPTH),
    .DUR_W   (DUR_W),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .note_in  (note_in),
    .write_on (write_on),
    .play     (play),
    .stop     (stop),
    .note_out (note_out),
    .recording(recording),
    .playing  (playing),
    .count    (count),
    .full     (full),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] note_map(input logic [3:0] n);
    return n[3] ? 4'd0 : n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_run(input logic [3:0] n, input int len);
    run_notes.push_back(n);
    run_lens.push_back(len);
  endtask

  // Model: a run becomes an entry if it lasted at least one tick and the
  // buffer still has room.
  task automatic model_store(input int r);
    exp_entry_t e;
    e.note = note_map(run_notes[r]);
    e.dur  = run_lens[r] / TICK_DIV;
    if (e.dur > 0 && exp_entries.size() < DEPTH) exp_entries.push_back(e);
  endtask

  // Plays back the queued runs while write_on is high, then releases it.
  // With poke set, a play+stop pulse is issued in REC and must be ignored.
  task automatic record_runs(input bit poke);
    int nr;
    nr = run_notes.size();
    exp_entries.delete();
    write_on = 1'b1;
    for (int r = 0; r < nr; r++) begin
      note_in = run_notes[r];
      if (r > 0) model_store(r - 1);
      for (int c = 0; c < run_lens[r]; c++) begin
        if (poke && r == 0 && c == 2) begin
          play = 1'b1;
          stop = 1'b1;
        end
        step();
        play = 1'b0;
        stop = 1'b0;
        if (r == 0 && c == 0)
          check("rec_entry", {recording, note_out}, {1'b1, note_map(run_notes[0])});
        if (poke && r == 0 && c == 3)
          check("rec_ignores_play", {recording, playing}, 2'b10);
      end
    end
    check("rec_hold", {recording, count}, {1'b1, 7'(exp_entries.size())});
    model_store(nr - 1);
    write_on = 1'b0;
    step();
    check("rec_exit", {recording, full, count},
          {1'b0, exp_entries.size() == DEPTH, 7'(exp_entries.size())});
    run_notes.delete();
    run_lens.delete();
  endtask

  // Pulses play and checks every playback cycle against the scoreboard.
  task automatic play_and_check(input string tag);
    note_in = 4'd2;
    play    = 1'b1;
    step();
    play = 1'b0;
    foreach (exp_entries[i])
      for (int k = 0; k < exp_entries[i].dur * TICK_DIV; k++)
        sb.push_back({1'b0, 1'b1, exp_entries[i].note});
`ifdef NOTE_REC_LOOP_EN
    sb.push_back({1'b0, 1'b1, exp_entries[0].note});
`else
    sb.push_back({1'b1, 1'b0, 4'd0});
`endif
    while (sb.size() > 0) begin
      check(tag, {done, playing, note_out}, sb.pop_front());
      if (sb.size() > 0) step();
    end
`ifdef NOTE_REC_LOOP_EN
    stop = 1'b1;
    step();
    stop = 1'b0;
    check({tag, "_loop_stop"}, {done, playing}, 2'b00);
`endif
    step();
    check({tag, "_after"}, {done, playing, note_out}, {1'b0, 1'b0, 4'd2});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset    = 1'b0;
    note_in  = 4'd7;
    write_on = 1'b0;
    play     = 1'b0;
    stop     = 1'b0;
    repeat (3) step();
    check("reset_outputs", {note_out, recording, playing, count, full, done}, '0);
    reset = 1'b1;
    step();

    // IDLE pass-through with rest mapping
    note_in = 4'd9;
    step();
    check("idle_map_rest", note_out, 4'd0);
    note_in = 4'd7;
    step();
    check("idle_follow", note_out, 4'd7);

    // play with an empty buffer is ignored
    play = 1'b1;
    step();
    play = 1'b0;
    check("play_empty", {playing, count}, '0);

    // Basic record and playback
    add_run(4'd3, 8);
    add_run(4'd5, 12);
    record_runs(1'b0);
    play_and_check("play_basic");
    play_and_check("play_again");

    // Glitch rejection, with play/stop ignored in REC
    add_run(4'd1, 8);
    add_run(4'd6, 2);
    add_run(4'd1, 8);
    record_runs(1'b1);
    play_and_check("play_glitch");

    // Buffer fills at DEPTH
    for (int i = 1; i <= 6; i++) add_run(4'(i), 8);
    record_runs(1'b0);
    play_and_check("play_full");

    // Abort with stop mid-entry 0
    play = 1'b1;
    step();
    play = 1'b0;
    repeat (3) step();
    stop    = 1'b1;
    note_in = 4'd5;
    step();
    stop = 1'b0;
    check("stop_abort", {done, playing, note_out}, {1'b0, 1'b0, 4'd5});
    for (int i = 0; i < 20; i++) begin
      step();
      check("stop_no_done", done, 1'b0);
    end

    // Abort with write_on; no recording without a fresh rising edge
    play = 1'b1;
    step();
    play = 1'b0;
    check("play_start", playing, 1'b1);
    step();
    write_on = 1'b1;
    step();
    check("wr_abort", {recording, playing}, 2'b00);
    repeat (3) step();
    check("wr_no_rec", recording, 1'b0);
    write_on = 1'b0;
    step();
    check("count_persist", count, 7'd4);

    // stop in IDLE is ignored
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_idle", {playing, recording, count}, {2'b00, 7'd4});

    // Asynchronous reset mid-PLAY
    play = 1'b1;
    step();
    play = 1'b0;
    repeat (4) step();
    #2 reset = 1'b0;
    #1;
    check("reset_async", {note_out, recording, playing, count, full, done}, '0);
    step();
    reset = 1'b1;
    step();
    check("reset_count", count, 7'd0);
    play = 1'b1;
    step();
    play = 1'b0;
    check("reset_play_empty", playing, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
